// File: rtl/simon_cfg_pkg.sv
// Shared types for the simon config-bus AXI4-Lite initiator.
package simon_cfg_pkg;

   localparam int unsigned CFG_ADDR_W = 32;
   localparam int unsigned CFG_DATA_W = 32;
   localparam int unsigned CFG_STRB_W = 4;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      WR_REQ,
      WR_RESP,
      RD_REQ,
      RD_RESP,
      RSP
   } cfg_init_state_t;

   typedef struct packed {
      logic                  write;
      logic [CFG_ADDR_W-1:0] addr;
      logic [CFG_DATA_W-1:0] wdata;
      logic [CFG_STRB_W-1:0] wstrb;
   } cfg_cmd_t;

endpackage

// File: rtl/simon_cfg_axil_initiator.sv
// Turns single valid/ready commands into AXI4-Lite transfers on the simon config bus,
// one outstanding transaction, with a sticky stall watchdog.
module simon_cfg_axil_initiator
   import simon_cfg_pkg::*;
#(
   parameter int unsigned CFG_ADDR_WIDTH = 32,
   parameter int unsigned CFG_DATA_WIDTH = 32,
   parameter int unsigned CFG_STRB_WIDTH = 4,
   parameter int unsigned CFG_PROT_WIDTH = 1,
   parameter int unsigned CFG_RESP_WIDTH = 2,
   parameter int unsigned STALL_CYCLES   = 1024
) (
   input  logic                      simon_cfg_clk,
   input  logic                      simon_cfg_rstn,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic                      cmd_write,
   input  logic [CFG_ADDR_WIDTH-1:0] cmd_addr,
   input  logic [CFG_DATA_WIDTH-1:0] cmd_wdata,
   input  logic [CFG_STRB_WIDTH-1:0] cmd_wstrb,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic                      rsp_write,
   output logic [CFG_DATA_WIDTH-1:0] rsp_rdata,
   output logic [CFG_RESP_WIDTH-1:0] rsp_resp,
   output logic                      stall_err,
   output logic                      busy,
   output logic [CFG_ADDR_WIDTH-1:0] simon_cfg_awaddr,
   output logic [CFG_PROT_WIDTH-1:0] simon_cfg_awprot,
   output logic                      simon_cfg_awvalid,
   input  logic                      simon_cfg_awready,
   output logic [CFG_DATA_WIDTH-1:0] simon_cfg_wdata,
   output logic [CFG_STRB_WIDTH-1:0] simon_cfg_wstrb,
   output logic                      simon_cfg_wvalid,
   input  logic                      simon_cfg_wready,
   input  logic [CFG_RESP_WIDTH-1:0] simon_cfg_bresp,
   input  logic                      simon_cfg_bvalid,
   output logic                      simon_cfg_bready,
   output logic [CFG_ADDR_WIDTH-1:0] simon_cfg_araddr,
   output logic [CFG_PROT_WIDTH-1:0] simon_cfg_arprot,
   output logic                      simon_cfg_arvalid,
   input  logic                      simon_cfg_arready,
   input  logic [CFG_DATA_WIDTH-1:0] simon_cfg_rdata,
   input  logic [CFG_RESP_WIDTH-1:0] simon_cfg_rresp,
   input  logic                      simon_cfg_rvalid,
   output logic                      simon_cfg_rready
);

   localparam int unsigned CNT_W = 16;

   cfg_init_state_t  state;
   cfg_cmd_t         cmd_q;
   logic             aw_done;
   logic             w_done;
   logic [CNT_W-1:0] stall_cnt;

   logic accept, aw_hs, w_hs, b_hs, ar_hs, r_hs, any_hs, waiting;

   assign accept  = cmd_valid & cmd_ready;
   assign aw_hs   = simon_cfg_awvalid & simon_cfg_awready;
   assign w_hs    = simon_cfg_wvalid & simon_cfg_wready;
   assign b_hs    = simon_cfg_bready & simon_cfg_bvalid;
   assign ar_hs   = simon_cfg_arvalid & simon_cfg_arready;
   assign r_hs    = simon_cfg_rready & simon_cfg_rvalid;
   assign any_hs  = accept | aw_hs | w_hs | b_hs | ar_hs | r_hs;
   assign waiting = simon_cfg_awvalid | simon_cfg_wvalid | simon_cfg_arvalid
                  | simon_cfg_bready | simon_cfg_rready;

   // Address/data come straight from the command register, so they cannot move under a valid.
   assign simon_cfg_awaddr = CFG_ADDR_WIDTH'(cmd_q.addr);
   assign simon_cfg_araddr = CFG_ADDR_WIDTH'(cmd_q.addr);
   assign simon_cfg_wdata  = CFG_DATA_WIDTH'(cmd_q.wdata);
   assign simon_cfg_wstrb  = CFG_STRB_WIDTH'(cmd_q.wstrb);
   assign simon_cfg_awprot = '0;
   assign simon_cfg_arprot = '0;

   // Transaction sequencer.
   always_ff @(posedge simon_cfg_clk or negedge simon_cfg_rstn) begin
      if (!simon_cfg_rstn) begin
         state             <= IDLE;
         cmd_q             <= '0;
         aw_done           <= 1'b0;
         w_done            <= 1'b0;
         cmd_ready         <= 1'b0;
         busy              <= 1'b0;
         simon_cfg_awvalid <= 1'b0;
         simon_cfg_wvalid  <= 1'b0;
         simon_cfg_bready  <= 1'b0;
         simon_cfg_arvalid <= 1'b0;
         simon_cfg_rready  <= 1'b0;
         rsp_valid         <= 1'b0;
         rsp_write         <= 1'b0;
         rsp_rdata         <= '0;
         rsp_resp          <= '0;
      end else begin
         case (state)
            IDLE: begin
               cmd_ready <= 1'b1;
               if (accept) begin
                  cmd_q     <= '{write: cmd_write,
                                 addr:  CFG_ADDR_W'(cmd_addr),
                                 wdata: CFG_DATA_W'(cmd_wdata),
                                 wstrb: CFG_STRB_W'(cmd_wstrb)};
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  aw_done   <= 1'b0;
                  w_done    <= 1'b0;
                  if (cmd_write) begin
                     simon_cfg_awvalid <= 1'b1;
                     simon_cfg_wvalid  <= 1'b1;
                     state             <= WR_REQ;
                  end else begin
                     simon_cfg_arvalid <= 1'b1;
                     state             <= RD_REQ;
                  end
               end
            end
            WR_REQ: begin
               if (aw_hs) begin
                  simon_cfg_awvalid <= 1'b0;
                  aw_done           <= 1'b1;
               end
               if (w_hs) begin
                  simon_cfg_wvalid <= 1'b0;
                  w_done           <= 1'b1;
               end
               if ((aw_done | aw_hs) & (w_done | w_hs)) begin
                  simon_cfg_bready <= 1'b1;
                  state            <= WR_RESP;
               end
            end
            WR_RESP: begin
               if (simon_cfg_bvalid) begin
                  simon_cfg_bready <= 1'b0;
                  rsp_valid        <= 1'b1;
                  rsp_write        <= cmd_q.write;
                  rsp_rdata        <= '0;
                  rsp_resp         <= simon_cfg_bresp;
                  state            <= RSP;
               end
            end
            RD_REQ: begin
               if (ar_hs) begin
                  simon_cfg_arvalid <= 1'b0;
                  simon_cfg_rready  <= 1'b1;
                  state             <= RD_RESP;
               end
            end
            RD_RESP: begin
               if (simon_cfg_rvalid) begin
                  simon_cfg_rready <= 1'b0;
                  rsp_valid        <= 1'b1;
                  rsp_write        <= cmd_q.write;
                  rsp_rdata        <= simon_cfg_rdata;
                  rsp_resp         <= simon_cfg_rresp;
                  state            <= RSP;
               end
            end
            RSP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  busy      <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Stall watchdog: flags, but never aborts, a channel that stops making progress.
   always_ff @(posedge simon_cfg_clk or negedge simon_cfg_rstn) begin
      if (!simon_cfg_rstn) begin
         stall_cnt <= '0;
         stall_err <= 1'b0;
      end else begin
         if (any_hs)
            stall_cnt <= '0;
         else if (waiting && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + CNT_W'(1);

         if (accept)
            stall_err <= 1'b0;
         else if (waiting && !any_hs && ((32'(stall_cnt) + 32'd1) >= STALL_CYCLES))
            stall_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_simon_cfg_axil_initiator.sv
// Self-checking bench: table of commands against a delay-programmable AXI-Lite responder.
module tb_simon_cfg_axil_initiator;
   import simon_cfg_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        cmd_valid, cmd_ready, cmd_write, rsp_valid, rsp_ready, rsp_write;
   logic [31:0] cmd_addr, cmd_wdata, rsp_rdata;
   logic [3:0]  cmd_wstrb;
   logic [1:0]  rsp_resp;
   logic        stall_err, busy;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic [0:0]  awprot, arprot;
   logic [3:0]  wstrb;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [1:0]  bresp, rresp;

   simon_cfg_axil_initiator #(.STALL_CYCLES(8)) dut (
      .simon_cfg_clk(clk), .simon_cfg_rstn(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
      .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .stall_err(stall_err), .busy(busy),
      .simon_cfg_awaddr(awaddr), .simon_cfg_awprot(awprot), .simon_cfg_awvalid(awvalid),
      .simon_cfg_awready(awready), .simon_cfg_wdata(wdata), .simon_cfg_wstrb(wstrb),
      .simon_cfg_wvalid(wvalid), .simon_cfg_wready(wready), .simon_cfg_bresp(bresp),
      .simon_cfg_bvalid(bvalid), .simon_cfg_bready(bready), .simon_cfg_araddr(araddr),
      .simon_cfg_arprot(arprot), .simon_cfg_arvalid(arvalid), .simon_cfg_arready(arready),
      .simon_cfg_rdata(rdata), .simon_cfg_rresp(rresp), .simon_cfg_rvalid(rvalid),
      .simon_cfg_rready(rready)
   );

   typedef struct {
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
      logic [1:0]  resp;
      logic [31:0] rdata;
      logic [31:0] exp_rdata;
      logic [1:0]  exp_resp;
   } vec_t;

   typedef struct {
      logic        write;
      logic [31:0] rdata;
      logic [1:0]  resp;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_fail = 0;

   vec_t cur;
   logic ar_block = 1'b0;
   int   aw_n, w_n, b_n, ar_n, r_n;
   int   aw_c, w_c, b_c, ar_c, r_c;
   logic b_pend, r_pend, b_drop, r_drop, b_sent, r_sent;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] s, input int awd, input int wd, input int bd,
                               input int ard, input int rd, input logic [1:0] rsp,
                               input logic [31:0] rdat, input logic [31:0] erd,
                               input logic [1:0] ers);
      vec_t v;
      v.write = w; v.addr = a; v.wdata = d; v.wstrb = s;
      v.aw_dly = awd; v.w_dly = wd; v.b_dly = bd; v.ar_dly = ard; v.r_dly = rd;
      v.resp = rsp; v.rdata = rdat; v.exp_rdata = erd; v.exp_resp = ers;
      return v;
   endfunction

   // Responder: drives readies/responses on the falling edge; a handshake is counted
   // when both sides are high at the falling edge, i.e. it completes on the next rise.
   initial begin
      awready = 0; wready = 0; bvalid = 0; bresp = 0;
      arready = 0; rvalid = 0; rdata = 0; rresp = 0;
      aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
      b_pend = 0; r_pend = 0; b_drop = 0; r_drop = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
            aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
            b_pend = 0; r_pend = 0; b_drop = 0; r_drop = 0;
         end else begin
            if (b_drop) begin bvalid = 0; b_drop = 0; end
            if (b_pend && !bvalid) begin
               if (b_c >= cur.b_dly) begin bvalid = 1; bresp = cur.resp; b_pend = 0; b_c = 0; end
               else b_c++;
            end
            if (bvalid && bready) begin b_n++; b_drop = 1; end

            if (r_drop) begin rvalid = 0; r_drop = 0; end
            if (r_pend && !rvalid) begin
               if (r_c >= cur.r_dly) begin
                  rvalid = 1; rdata = cur.rdata; rresp = cur.resp; r_pend = 0; r_c = 0;
               end else r_c++;
            end
            if (rvalid && rready) begin r_n++; r_drop = 1; end

            if (awvalid) begin
               chk("awaddr", awaddr, cur.addr);
               if (aw_c >= cur.aw_dly) begin awready = 1; aw_n++; end
               else begin awready = 0; aw_c++; end
            end else begin awready = 0; aw_c = 0; end

            if (wvalid) begin
               chk("wdata", wdata, cur.wdata);
               chk("wstrb", 32'(wstrb), 32'(cur.wstrb));
               if (w_c >= cur.w_dly) begin wready = 1; w_n++; end
               else begin wready = 0; w_c++; end
            end else begin wready = 0; w_c = 0; end

            if (arvalid) begin
               chk("araddr", araddr, cur.addr);
               if (!ar_block && ar_c >= cur.ar_dly) begin arready = 1; ar_n++; end
               else begin arready = 0; ar_c++; end
            end else begin arready = 0; ar_c = 0; end

            if (aw_n > 0 && w_n > 0 && !b_sent) begin b_pend = 1; b_sent = 1; end
            if (ar_n > 0 && !r_sent) begin r_pend = 1; r_sent = 1; end
         end
      end
   end

   task automatic start_txn(input vec_t v);
      cur = v;
      aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_n = 0;
      b_sent = 0; r_sent = 0;
   endtask

   // Present a command at a falling edge and wait for it to be accepted.
   task automatic issue(input vec_t v);
      int t;
      exp_t e;
      start_txn(v);
      cmd_valid = 1; cmd_write = v.write; cmd_addr = v.addr;
      cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
      t = 0;
      while (!cmd_ready && t < 20) begin @(negedge clk); t++; end
      chk("cmd_accept", 32'(cmd_ready), 32'd1);
      if (cmd_ready) begin
         e.write = v.write; e.rdata = v.exp_rdata; e.resp = v.exp_resp;
         sb.push_back(e);
      end
      @(negedge clk);
      cmd_valid = 0;
      chk("busy_after_accept", 32'(busy), 32'd1);
      chk("cmd_ready_after_accept", 32'(cmd_ready), 32'd0);
   endtask

   task automatic wait_rsp(input int lim);
      int t;
      exp_t e;
      rsp_ready = 1;
      t = 0;
      while (!rsp_valid && t < lim) begin @(negedge clk); t++; end
      chk("rsp_valid", 32'(rsp_valid), 32'd1);
      if (rsp_valid) begin
         if (sb.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_rsp: actual response present, required none");
         end else begin
            e = sb.pop_front();
            chk("rsp_write", 32'(rsp_write), 32'(e.write));
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_resp", 32'(rsp_resp), 32'(e.resp));
         end
         @(negedge clk);
         chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
         chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
         chk("busy_idle", 32'(busy), 32'd0);
      end
      rsp_ready = 0;
   endtask

   task automatic run_txn(input vec_t v);
      issue(v);
      wait_rsp(100);
      chk("aw_count", aw_n, v.write ? 32'd1 : 32'd0);
      chk("w_count", w_n, v.write ? 32'd1 : 32'd0);
      chk("b_count", b_n, v.write ? 32'd1 : 32'd0);
      chk("ar_count", ar_n, v.write ? 32'd0 : 32'd1);
      chk("r_count", r_n, v.write ? 32'd0 : 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "time limit reached");
   end

   initial begin
      vec_t tbl[6];
      vec_t hv, sv, rv;
      int   t;
      int   seen;

      tbl[0] = mk(1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 2, 0, 0,
                  RESP_OKAY, 32'h0, 32'h0, RESP_OKAY);
      tbl[1] = mk(1, 32'h0000_0020, 32'hCAFE_F00D, 4'h3, 0, 5, 0, 0, 0,
                  RESP_OKAY, 32'h0, 32'h0, RESP_OKAY);
      tbl[2] = mk(0, 32'h0000_0004, 32'h0, 4'h0, 0, 0, 0, 0, 1,
                  RESP_SLVERR, 32'h1234_5678, 32'h1234_5678, RESP_SLVERR);
      tbl[3] = mk(1, 32'h0000_0008, 32'h0102_0304, 4'h1, 3, 0, 1, 0, 0,
                  RESP_DECERR, 32'hFFFF_FFFF, 32'h0, RESP_DECERR);
      tbl[4] = mk(0, 32'h0000_000C, 32'h0, 4'h0, 0, 0, 0, 2, 0,
                  RESP_OKAY, 32'hA5A5_5A5A, 32'hA5A5_5A5A, RESP_OKAY);
      tbl[5] = mk(1, 32'h0000_0014, 32'h7777_8888, 4'hC, 4, 2, 3, 0, 0,
                  RESP_EXOKAY, 32'h0, 32'h0, RESP_EXOKAY);

      cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
      rsp_ready = 0;
      start_txn(tbl[0]);

      repeat (3) @(negedge clk);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("rst_valids", 32'({awvalid, wvalid, arvalid, bready, rready}), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_stall_busy", 32'({stall_err, busy}), 32'd0);
      chk("rst_addr", awaddr | araddr | wdata, 32'd0);
      rst_n = 1;
      @(negedge clk);
      chk("out_of_reset_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("prot", 32'({awprot, arprot}), 32'd0);

      for (int i = 0; i < 6; i++) run_txn(tbl[i]);

      // Response held off: payload stable, nothing new accepted or issued.
      hv = mk(1, 32'h0000_0030, 32'h1111_2222, 4'hF, 0, 0, 0, 0, 0,
              RESP_SLVERR, 32'h0, 32'h0, RESP_SLVERR);
      issue(hv);
      t = 0;
      while (!rsp_valid && t < 30) begin @(negedge clk); t++; end
      cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h0000_0040;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
         chk("hold_rsp_write", 32'(rsp_write), 32'd1);
         chk("hold_rsp_rdata", rsp_rdata, 32'd0);
         chk("hold_rsp_resp", 32'(rsp_resp), 32'(RESP_SLVERR));
         chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
         chk("hold_no_req", 32'({awvalid, arvalid}), 32'd0);
      end
      cmd_valid = 0;
      wait_rsp(5);
      chk("hold_ar_count", ar_n, 32'd0);
      chk("hold_aw_count", aw_n, 32'd1);

      // Stalled read: error flag set but transaction continues.
      sv = mk(0, 32'h0000_0050, 32'h0, 4'h0, 0, 0, 0, 0, 0,
              RESP_OKAY, 32'h0BAD_F00D, 32'h0BAD_F00D, RESP_OKAY);
      ar_block = 1;
      issue(sv);
      repeat (4) @(negedge clk);
      chk("stall_early", 32'(stall_err), 32'd0);
      repeat (8) @(negedge clk);
      chk("stall_set", 32'(stall_err), 32'd1);
      chk("stall_arvalid_held", 32'(arvalid), 32'd1);
      ar_block = 0;
      wait_rsp(50);
      chk("stall_sticky", 32'(stall_err), 32'd1);
      issue(tbl[0]);
      chk("stall_cleared_on_accept", 32'(stall_err), 32'd0);
      wait_rsp(100);

      // Reset while waiting for B abandons the write.
      rv = mk(1, 32'h0000_0060, 32'h5555_AAAA, 4'hF, 0, 0, 40, 0, 0,
              RESP_OKAY, 32'h0, 32'h0, RESP_OKAY);
      issue(rv);
      t = 0;
      while (!bready && t < 20) begin @(negedge clk); t++; end
      chk("wr_resp_bready", 32'(bready), 32'd1);
      rst_n = 0;
      #1;
      chk("async_rst_valids", 32'({awvalid, wvalid, arvalid, bready, rready}), 32'd0);
      chk("async_rst_rsp", 32'({rsp_valid, cmd_ready}), 32'd0);
      chk("async_rst_flags", 32'({stall_err, busy}), 32'd0);
      chk("async_rst_data", awaddr | wdata | araddr, 32'd0);
      chk("async_rst_wstrb", 32'(wstrb), 32'd0);
      sb.delete();
      @(negedge clk);
      rst_n = 1;
      repeat (2) @(negedge clk);
      chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("post_rst_busy", 32'(busy), 32'd0);
      seen = 0;
      for (int k = 0; k < 45; k++) begin
         @(negedge clk);
         if (rsp_valid) seen++;
      end
      chk("post_rst_no_rsp", seen, 32'd0);
      run_txn(tbl[2]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
